// File: rtl/disp_scan.sv
// Six-digit multiplexed 7-segment scan generator for the HH:MM:SS display.
// Emits one {seg, sel, leds} frame word per digit slot, with a 1-cycle valid for the 74HC595 writer.
module disp_scan #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 50,
    parameter bit SEG_ACT_LOW  = 1'b0,
    parameter bit DIG_ACT_LOW  = 1'b0
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [23:0] i_DIGITS,
    input  logic [5:0]  i_DOTS,
    input  logic [5:0]  i_BLINK,
    input  logic        i_LZB,
    input  logic [7:0]  i_LEDS,
    output logic [23:0] o_DATA,
    output logic        o_VALID
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = $clog2(BLINK_FRAMES) + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    // The serial writer needs 48 shift clocks plus a latch pulse per word.
    if (REFRESH_DIV < 64) begin : g_bad_refresh_div
        $error("disp_scan: REFRESH_DIV must be >= 64");
    end

    logic [PRE_W-1:0] pre_cnt;
    logic [2:0]       idx;
    logic [23:0]      snap;
    logic [BLK_W-1:0] blink_cnt;
    logic             phase;

    logic             tc;
    logic [23:0]      src;
    logic [3:0]       nib;
    logic [7:0]       seg;
    logic [5:0]       sel;
    logic [23:0]      word;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        tc  = (pre_cnt == PRE_LAST);
        // Slot 0 reads live digits (and snapshots them); later slots reuse the snapshot.
        src = (idx == 3'd0) ? i_DIGITS : snap;
        case (idx)
            3'd0:    nib = src[23:20];
            3'd1:    nib = src[19:16];
            3'd2:    nib = src[15:12];
            3'd3:    nib = src[11:8];
            3'd4:    nib = src[7:4];
            3'd5:    nib = src[3:0];
            default: nib = 4'd0;
        endcase
        seg = {i_DOTS[idx], seg_decode(nib)};
        if ((idx == 3'd0) && i_LZB && (nib == 4'd0)) begin
            seg = 8'h00;
        end
        if (phase && i_BLINK[idx]) begin
            seg = 8'h00;
        end
        sel  = 6'b00_0001 << idx;
        word = {seg ^ {8{SEG_ACT_LOW}}, 2'b00, sel ^ {6{DIG_ACT_LOW}}, i_LEDS};
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            pre_cnt   <= '0;
            idx       <= 3'd0;
            snap      <= 24'h0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            o_DATA    <= 24'h0;
            o_VALID   <= 1'b0;
        end else begin
            o_VALID <= 1'b0;
            if (tc) begin
                pre_cnt <= '0;
                o_DATA  <= word;
                o_VALID <= 1'b1;
                idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                if (idx == 3'd0) begin
                    snap <= i_DIGITS;
                end
                if (idx == 3'd5) begin
                    if (blink_cnt == BLK_LAST) begin
                        blink_cnt <= '0;
                        phase     <= ~phase;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan: an active-high instance and an inverted-polarity
// instance share stimulus; a monitor enforces exact pulse spacing.
module tb_disp_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] digits;
    logic [5:0]  dots;
    logic [5:0]  blink;
    logic        lzb;
    logic [7:0]  leds;
    logic [23:0] data;
    logic        valid;
    logic [23:0] data_inv;
    logic        valid_inv;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    disp_scan #(.REFRESH_DIV(64), .BLINK_FRAMES(2), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut (
        .i_CLK(clk), .i_RST(rst), .i_DIGITS(digits), .i_DOTS(dots), .i_BLINK(blink),
        .i_LZB(lzb), .i_LEDS(leds), .o_DATA(data), .o_VALID(valid)
    );

    disp_scan #(.REFRESH_DIV(64), .BLINK_FRAMES(2), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut_inv (
        .i_CLK(clk), .i_RST(rst), .i_DIGITS(digits), .i_DOTS(dots), .i_BLINK(blink),
        .i_LZB(lzb), .i_LEDS(leds), .o_DATA(data_inv), .o_VALID(valid_inv)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for the next o_VALID; n = falling edges waited.
    task automatic wait_pulse(input string tag, output logic [23:0] d, output int n);
        logic found;
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (valid) found = 1'b1;
        end
        chk({tag, "_seen"}, {31'b0, found}, 32'd1);
        d = data;
    endtask

    task automatic expect_pulse(input string tag, input logic [23:0] exp);
        logic [23:0] d;
        int n;
        wait_pulse(tag, d, n);
        chk(tag, {8'h0, d}, {8'h0, exp});
    endtask

    // Pulse spacing monitor, sampled 1 time unit after the active edge.
    int  last_pulse = 0;
    bit  armed      = 1'b0;
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst) begin
            armed = 1'b0;
        end else if (valid) begin
            if (armed) chk("pulse_gap", cyc - last_pulse, 32'd64);
            armed      = 1'b1;
            last_pulse = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] seg_tab [6];
    logic [23:0] d;
    int n;

    initial begin
        seg_tab = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D};
        rst    = 1'b1;
        digits = 24'h123456;
        dots   = 6'b0;
        blink  = 6'b0;
        lzb    = 1'b0;
        leds   = 8'hA5;
        repeat (2) @(negedge clk);
        chk("rst_data", {8'h0, data}, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_data_inv", {8'h0, data_inv}, 32'h0);
        rst = 1'b0;

        // Basic scan of 123456 with latency
        wait_pulse("slot0", d, n);
        chk("slot0_lat", n, 32'd64);
        chk("slot0", {8'h0, d}, 32'h06_01_A5);
        chk("slot0_inv", {8'h0, data_inv}, 32'hF9_3E_A5);
        wait_pulse("slot1", d, n);
        chk("slot1_lat", n, 32'd64);
        chk("slot1", {8'h0, d}, 32'h5B_02_A5);
        chk("slot1_inv", {8'h0, data_inv}, 32'hA4_3D_A5);
        expect_pulse("slot2", 24'h4F_04_A5);
        expect_pulse("slot3", 24'h66_08_A5);

        // Digits change mid-frame: snapshot holds until the next slot 0
        digits = 24'h987654;
        expect_pulse("snap_slot4", 24'h6D_10_A5);
        expect_pulse("snap_slot5", 24'h7D_20_A5);
        wait_pulse("new_slot0", d, n);
        chk("new_slot0_lat", n, 32'd64);
        chk("new_slot0", {8'h0, d}, 32'h6F_01_A5);
        expect_pulse("new_slot1", 24'h7F_02_A5);
        for (int i = 0; i < 4; i++) wait_pulse("skip", d, n);

        // Leading-zero blanking, hex blank and decimal points
        digits = 24'h0F0000;
        lzb    = 1'b1;
        dots   = 6'b000011;
        wait_pulse("lzb_slot0", d, n);
        chk("lzb_slot0", {8'h0, d}, 32'h00_01_A5);
        chk("lzb_slot0_inv", {8'h0, data_inv}, 32'hFF_3E_A5);
        expect_pulse("hexF_dp_slot1", 24'h80_02_A5);
        expect_pulse("zero_slot2", 24'h3F_04_A5);
        for (int i = 0; i < 3; i++) wait_pulse("skip", d, n);
        lzb  = 1'b0;
        dots = 6'b0;
        expect_pulse("nolzb_slot0", 24'h3F_01_A5);
        expect_pulse("blank_slot1", 24'h00_02_A5);

        // Reset at pre_cnt=30 of slot 2, then blink over five frames
        repeat (30) @(negedge clk);
        digits = 24'h123456;
        blink  = 6'b000001;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 30; p++) begin
            int slot;
            int frame;
            logic [7:0] s;
            slot  = p % 6;
            frame = p / 6;
            s = seg_tab[slot];
            if (slot == 0 && (frame == 2 || frame == 3)) s = 8'h00;
            wait_pulse("blink", d, n);
            if (p == 0) chk("post_rst_lat", n, 32'd64);
            chk($sformatf("blink_f%0d_s%0d", frame, slot), {8'h0, d},
                {8'h0, s, 2'b00, 6'(6'b1 << slot), 8'hA5});
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
